// File: rtl/regfile_mp_sb_if.sv
// Bus interface for regfile_mp_sb: read ports, write-back port, issue (busy-set) port and
// the init_done status. The master side is the decode/issue logic, the slave side the file.
interface regfile_mp_sb_if #(
   parameter int XLEN = 32,
   parameter int NRD  = 2,
   parameter int AW   = 5
);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                set_en;
   logic [AW-1:0]       set_addr;
   logic                init_done;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr,
      input  rd_data, rd_busy, init_done
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr,
      output rd_data, rd_busy, init_done
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// After reset a clear sequencer zeroes one register per cycle (INIT), then the file
// runs until the next reset (RUN). Register 0 always reads zero and is never busy.
// Optional build macro: REGFILE_BYPASS_EN forwards the write-back value to matching
// read ports in the same cycle.
module regfile_mp_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = 5
) (
   input logic               clk,
   input logic               rst_n,
   regfile_mp_sb_if.slave    bus
);

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
   logic            init_done_q, init_done_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic [XLEN-1:0] regs [NREG];

   logic            run;
   logic            wr_ok;
   logic            set_ok;
   logic [AW-1:0]   ra;

   // An address is architectural and writable when nonzero and inside the file.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NREG);
   endfunction

   assign run            = (state_q == S_RUN);
   assign wr_ok          = run && bus.wr_en  && addr_ok(bus.wr_addr);
   assign set_ok         = run && bus.set_en && addr_ok(bus.set_addr);
   assign bus.init_done  = init_done_q;

   // Clear sequencer next state: walk every index once, then park in RUN.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
      if (state_q == S_INIT) begin
         clr_cnt_d = clr_cnt_q + AW'(1);
         if (int'(clr_cnt_q) == NREG - 1) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
         end
      end
   end

   // Scoreboard next state: retiring write clears, issue sets; set is applied last so it wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[bus.wr_addr]  = 1'b0;
      if (set_ok) busy_d[bus.set_addr] = 1'b1;
   end

   // Control state: FSM, clear counter, init_done and busy bits, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q     <= S_INIT;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
      end
   end

   // Register array: zeroed by the sequencer during INIT, written by write-back in RUN.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch; the clear sequencer zeroes it so it maps to plain RAM.
      if (rst_n) begin
         if (state_q == S_INIT) begin
            regs[clr_cnt_q] <= '0;
         end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
         end
      end
   end

   // Combinational read ports with optional same-cycle write-back forwarding.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      ra          = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = bus.rd_addr[i*AW +: AW];
         if (run && addr_ok(ra)) begin
            bus.rd_data[i*XLEN +: XLEN] = regs[ra];
            bus.rd_busy[i]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.wr_addr == ra)) begin
               bus.rd_data[i*XLEN +: XLEN] = bus.wr_data;
               bus.rd_busy[i]              = set_ok && (bus.set_addr == ra);
            end
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (XLEN=32, NREG=32, NRD=2, AW=5).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_regfile_mp_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;

   regfile_mp_sb_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus ();

   regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.rd_addr = {a1, a0};
      #1;
   endtask

   function automatic logic [31:0] rdata(input int p);
      return bus.rd_data[p*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] rbusy(input int p);
      return {31'b0, bus.rd_busy[p]};
   endfunction

   task automatic write(input logic [AW-1:0] a, input logic [31:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.set_en = 1'b0; bus.set_addr = '0;

      // Reset, then the first clear sequence with writes/sets to reg 9 that must be ignored.
      tick();
      check("reset_init_done", {31'b0, bus.init_done}, 32'd0);
      rst_n = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1234_5678;
      bus.set_en = 1'b1; bus.set_addr = 5'd9;
      set_rd(5'd9, 5'd9);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bus.init_done) begin n = i; break; end
         if (i == 5) begin
            check("init_rd_data", rdata(0), 32'd0);
            check("init_rd_busy", rbusy(1), 32'd0);
         end
      end
      bus.wr_en = 1'b0; bus.set_en = 1'b0;
      #1;
      check("init_len", n, NREG);
      check("init_wr_ignored", rdata(0), 32'd0);
      check("init_set_ignored", rbusy(0), 32'd0);

      // Every register reads zero after the clear, on both ports.
      for (int a = 0; a < NREG; a++) begin
         set_rd(AW'(a), AW'(NREG - 1 - a));
         check("clear_p0", rdata(0), 32'd0);
         check("clear_p1", rdata(1), 32'd0);
      end

      // Basic write and duplicate-address read.
      set_rd(5'd0, 5'd0);
      write(5'd5, 32'hDEAD_BEEF);
      set_rd(5'd5, 5'd5);
      check("wr5_p0", rdata(0), 32'hDEAD_BEEF);
      check("wr5_dup_p1", rdata(1), 32'hDEAD_BEEF);

      // Writes to register 0 are dropped.
      write(5'd0, 32'h0000_0001);
      set_rd(5'd0, 5'd0);
      check("r0_p0", rdata(0), 32'd0);
      check("r0_p1", rdata(1), 32'd0);

      // Scoreboard: set, set+clear same reg (set wins), then clear.
      bus.set_en = 1'b1; bus.set_addr = 5'd7;
      set_rd(5'd7, 5'd0);
      check("set7_same_cycle", rbusy(0), 32'd0);
      tick();
      bus.set_en = 1'b0;
      #1;
      check("set7_next", rbusy(0), 32'd1);
      bus.set_en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
      #1;
      check("setclr7_data_pre", rdata(0), BYP ? 32'h77 : 32'd0);
      check("setclr7_busy_pre", rbusy(0), 32'd1);
      tick();
      bus.set_en = 1'b0; bus.wr_en = 1'b0;
      #1;
      check("setclr7_busy", rbusy(0), 32'd1);
      check("setclr7_data", rdata(0), 32'h77);
      write(5'd7, 32'h78);
      #1;
      check("clr7_busy", rbusy(0), 32'd0);
      check("clr7_data", rdata(0), 32'h78);

      // Set and clear of different registers in one cycle.
      bus.set_en = 1'b1; bus.set_addr = 5'd11;
      tick();
      bus.set_addr = 5'd10;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 32'hB0B0;
      tick();
      bus.set_en = 1'b0; bus.wr_en = 1'b0;
      set_rd(5'd10, 5'd11);
      check("diff_set10", rbusy(0), 32'd1);
      check("diff_clr11", rbusy(1), 32'd0);
      check("diff_data11", rdata(1), 32'hB0B0);

      // Write-back forwarding on port 1.
      set_rd(5'd0, 5'd3);
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h55;
      #1;
      check("byp_same_cycle", rdata(1), BYP ? 32'h55 : 32'd0);
      check("byp_busy", rbusy(1), 32'd0);
      tick();
      bus.wr_en = 1'b0;
      #1;
      check("byp_next_cycle", rdata(1), 32'h55);

      // Mid-RUN reset: busy cleared, in-flight write dropped, full clear reruns.
      for (int a = 1; a <= 4; a++) write(AW'(a), 32'h100 + a);
      bus.set_en = 1'b1; bus.set_addr = 5'd2;
      tick();
      bus.set_en = 1'b0;
      set_rd(5'd2, 5'd4);
      check("pre_rst_busy2", rbusy(0), 32'd1);
      check("pre_rst_data4", rdata(1), 32'h104);
      rst_n = 1'b0;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'hBAD;
      tick();
      rst_n = 1'b1; bus.wr_en = 1'b0;
      #1;
      check("rst_init_done", {31'b0, bus.init_done}, 32'd0);
      check("rst_busy2", rbusy(0), 32'd0);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bus.init_done) begin n = i; break; end
      end
      check("reinit_len", n, NREG);
      for (int a = 1; a <= 4; a++) begin
         set_rd(AW'(a), 5'd2);
         check("reinit_data", rdata(0), 32'd0);
         check("reinit_busy2", rbusy(1), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
